// File: rtl/circle_plot_sequencer.sv
// Midpoint circle sequencer: walks one octant and issues the 8 symmetric pixels per step
// as single ready/valid writes. Optional macro CIRCLE_DEDUP_EN skips duplicate points.
module circle_plot_sequencer #(
    parameter int CW = 9,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] cx,
    input  logic [CW-1:0] cy,
    input  logic [CW-1:0] radius,
    input  logic          color,
    output logic          busy,
    output logic          done,
    output logic          pix_we,
    input  logic          pix_ready,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          pix_wdata
);

    typedef enum logic [1:0] {S_IDLE, S_PLOT, S_STEP, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cx_q, cx_d, cy_q, cy_d;
    logic [CW-1:0]        x_q, x_d, y_q, y_d;
    logic signed [DW-1:0] d_q, d_d;
    logic [2:0]           idx_q, idx_d;
    logic                 col_q, col_d;
    logic                 skip;

    // Two extra bits so x-1 at x==0 goes negative and terminates the walk.
    logic signed [CW+1:0] x_nxt_s, y_nxt_s;
    logic signed [DW-1:0] xd, yd, d_step, d_init;
    logic                 d_neg, cont;

    always_comb begin
        d_neg   = d_q[DW-1];
        y_nxt_s = $signed({2'b00, y_q}) + $signed((CW+2)'(1));
        x_nxt_s = d_neg ? $signed({2'b00, x_q}) : $signed({2'b00, x_q}) - $signed((CW+2)'(1));
        yd      = DW'(y_nxt_s);
        xd      = DW'(x_nxt_s);
        d_step  = d_neg ? (d_q + (yd <<< 1) + DW'(1))
                        : (d_q + ((yd - xd) <<< 1) + DW'(1));
        d_init  = DW'(1) - $signed(DW'(radius));
        cont    = (x_nxt_s >= y_nxt_s);
    end

    always_comb begin
        pix_x = cx_q + x_q;
        pix_y = cy_q + y_q;
        case (idx_q)
            3'd0: begin pix_x = cx_q + x_q; pix_y = cy_q + y_q; end
            3'd1: begin pix_x = cx_q + x_q; pix_y = cy_q - y_q; end
            3'd2: begin pix_x = cx_q - x_q; pix_y = cy_q + y_q; end
            3'd3: begin pix_x = cx_q - x_q; pix_y = cy_q - y_q; end
            3'd4: begin pix_x = cx_q + y_q; pix_y = cy_q + x_q; end
            3'd5: begin pix_x = cx_q + y_q; pix_y = cy_q - x_q; end
            3'd6: begin pix_x = cx_q - y_q; pix_y = cy_q + x_q; end
            default: begin pix_x = cx_q - y_q; pix_y = cy_q - x_q; end
        endcase
        pix_wdata = col_q;
    end

`ifdef CIRCLE_DEDUP_EN
    always_comb begin
        skip = 1'b0;
        if ((y_q == '0) && (idx_q == 3'd1 || idx_q == 3'd3 || idx_q == 3'd6 || idx_q == 3'd7))
            skip = 1'b1;
        if ((x_q == '0) && (idx_q == 3'd2 || idx_q == 3'd3))
            skip = 1'b1;
        if ((x_q == y_q) && idx_q[2])
            skip = 1'b1;
    end
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        col_d   = col_q;
        x_d     = x_q;
        y_d     = y_q;
        d_d     = d_q;
        idx_d   = idx_q;
        busy    = 1'b0;
        done    = 1'b0;
        pix_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    cx_d    = cx;
                    cy_d    = cy;
                    col_d   = color;
                    x_d     = radius;
                    y_d     = '0;
                    d_d     = d_init;
                    idx_d   = '0;
                    state_d = S_PLOT;
                end
            end
            S_PLOT: begin
                busy   = 1'b1;
                pix_we = !skip;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (skip || pix_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7)
                        state_d = S_STEP;
                end
            end
            S_STEP: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    x_d     = x_nxt_s[CW-1:0];
                    y_d     = y_nxt_s[CW-1:0];
                    d_d     = d_step;
                    idx_d   = '0;
                    state_d = cont ? S_PLOT : S_DONE;
                end
            end
            default: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            col_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            col_q   <= col_d;
            x_q     <= x_d;
            y_q     <= y_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_circle_plot_sequencer.sv
// Self-checking bench for circle_plot_sequencer: directed and randomized circles
// compared against an arithmetic midpoint-circle model.
module tb_circle_plot_sequencer;

    logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic       color = 1'b0, pix_ready = 1'b0;
    logic [8:0] cx = '0, cy = '0, radius = '0;
    logic       busy, done, pix_we, pix_wdata;
    logic [8:0] pix_x, pix_y;

    int checks = 0, failures = 0;
    int done_cnt = 0;
    logic [18:0] got[$];
    logic [18:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [19:0] prev_out = '0;

    circle_plot_sequencer #(.CW(9), .DW(12)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cx(cx), .cy(cy), .radius(radius), .color(color),
        .busy(busy), .done(done), .pix_we(pix_we), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_wdata(pix_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Collect transfers and verify outputs hold while a write is stalled.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {12'd0, pix_we, pix_wdata, pix_x, pix_y}, {12'd0, prev_out});
            if (pix_we && pix_ready)
                got.push_back({pix_wdata, pix_x, pix_y});
            if (done)
                done_cnt++;
            prev_stall = pix_we && !pix_ready && !abort;
            prev_out   = {pix_we, pix_wdata, pix_x, pix_y};
        end
    end

    // Reference: midpoint circle written directly from the algorithm; returns step count.
    function automatic int build(input int cxv, input int cyv, input int r, input bit c);
        int x, y, d, steps;
        int px[8];
        int py[8];
        bit sk;
        x = r; y = 0; d = 1 - r; steps = 0;
        exp_q.delete();
        do begin
            steps++;
            px = '{cxv + x, cxv + x, cxv - x, cxv - x, cxv + y, cxv + y, cxv - y, cxv - y};
            py = '{cyv + y, cyv - y, cyv + y, cyv - y, cyv + x, cyv - x, cyv + x, cyv - x};
            for (int k = 0; k < 8; k++) begin
                sk = 1'b0;
`ifdef CIRCLE_DEDUP_EN
                if (y == 0 && (k == 1 || k == 3 || k == 6 || k == 7)) sk = 1'b1;
                if (x == 0 && (k == 2 || k == 3)) sk = 1'b1;
                if (x == y && k >= 4) sk = 1'b1;
`endif
                if (!sk)
                    exp_q.push_back({c, 9'(px[k] & 511), 9'(py[k] & 511)});
            end
            y++;
            if (d < 0) d += 2 * y + 1;
            else begin x--; d += 2 * (y - x) + 1; end
        end while (x >= y);
        return steps;
    endfunction

    // mode 0: ready=1; 1: ready toggles; 2: random ready plus input noise while busy.
    task automatic run(input int cxv, input int cyv, input int rv, input bit c,
                       input int mode, output int lat);
        int  cyc;
        bit  seen;
        @(posedge clk); #1;
        got.delete();
        start = 1'b1; cx = 9'(cxv); cy = 9'(cyv); radius = 9'(rv); color = c; pix_ready = 1'b1;
        @(posedge clk); #1;
        start = (mode == 2);
        cyc = 1; seen = 1'b0; lat = 0;
        while (!seen && cyc < 4000) begin
            case (mode)
                0: pix_ready = 1'b1;
                1: pix_ready = (cyc % 2) == 1;
                default: begin
                    pix_ready = ($urandom_range(0, 3) != 0);
                    cx = 9'($urandom); cy = 9'($urandom);
                    radius = 9'($urandom); color = 1'($urandom);
                end
            endcase
            @(negedge clk);
            if (cyc == 1) chk("busy_first", {31'd0, busy}, 32'd1);
            if (done) begin
                seen = 1'b1;
                lat  = cyc;
                chk("busy_in_done", {31'd0, busy}, 32'd0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("timeout", {31'd0, seen}, 32'd1);
        start = 1'b0; pix_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_done", {29'd0, busy, pix_we, done}, 32'd0);
        @(posedge clk); #1;
        chk("nwrites", got.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got.size()) chk("write", {13'd0, got[i]}, {13'd0, exp_q[i]});
    endtask

    initial begin
        int steps, lat, n0, dc;
        int wrap_idx;
        int pre_abort;
`ifdef CIRCLE_DEDUP_EN
        wrap_idx = 1; pre_abort = 1;
`else
        wrap_idx = 2; pre_abort = 2;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {26'd0, busy, done, pix_we, pix_wdata, pix_x[0], pix_y[0]}, 32'd0);
        chk("reset_addr", {14'd0, pix_x, pix_y}, 32'd0);
        reset_n = 1'b1;

        steps = build(100, 100, 0, 1'b1);
        run(100, 100, 0, 1'b1, 0, lat);
        chk("r0_lat", lat, 10);
`ifdef CIRCLE_DEDUP_EN
        chk("r0_count", got.size(), 1);
`else
        chk("r0_count", got.size(), 8);
`endif
        chk("r0_pixel", {13'd0, got[0]}, {13'd0, 1'b1, 9'd100, 9'd100});

        steps = build(100, 100, 5, 1'b1);
        chk("r5_steps", steps, 4);
        run(100, 100, 5, 1'b1, 0, lat);
        chk("r5_lat", lat, 37);

        steps = build(100, 100, 5, 1'b1);
        run(100, 100, 5, 1'b1, 1, lat);

        steps = build(2, 510, 4, 1'b0);
        run(2, 510, 4, 1'b0, 0, lat);
        chk("wrap_idx2", {13'd0, got[wrap_idx]}, {13'd0, 1'b0, 9'd510, 9'd510});
        chk("wrap_lat", lat, 9 * steps + 1);

        // Abort on the third PLOT cycle of r=5, with that write not accepted.
        @(posedge clk); #1;
        got.delete(); dc = done_cnt;
        start = 1'b1; cx = 9'd100; cy = 9'd100; radius = 9'd5; color = 1'b1; pix_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; pix_ready = 1'b0; abort = 1'b1;
        @(negedge clk);
        chk("abort_pending_we", {31'd0, pix_we}, 32'd1);
        @(posedge clk); #1; abort = 1'b0; pix_ready = 1'b1;
        @(negedge clk);
        chk("abort_idle", {30'd0, busy, pix_we}, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("abort_writes", got.size(), pre_abort);
        chk("abort_no_done", done_cnt, dc);

        // start together with abort in IDLE is ignored.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", {30'd0, busy, pix_we}, 32'd0);

        // Asynchronous reset mid-circle.
        @(posedge clk); #1;
        start = 1'b1; radius = 9'd5;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #2; reset_n = 1'b0;
        #1;
        chk("rst_mid_outs", {12'd0, busy, done, pix_we, pix_wdata, pix_x, pix_y}, 32'd0);
        @(posedge clk); #1; reset_n = 1'b1;
        n0 = got.size(); dc = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_no_writes", got.size(), n0);
        chk("rst_no_done", done_cnt, dc);
        chk("rst_idle", {31'd0, busy}, 32'd0);

        for (int t = 0; t < 5; t++) begin
            int rcx, rcy, rr;
            bit rc;
            rcx = $urandom_range(0, 511);
            rcy = $urandom_range(0, 511);
            rr  = $urandom_range(0, 40);
            rc  = 1'($urandom);
            steps = build(rcx, rcy, rr, rc);
            run(rcx, rcy, rr, rc, 2, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
